// File: rtl/bgu_dual_issue_cond.sv
// rtl/bgu_dual_issue_cond.sv - dual-issue branch/goto unit with conditional branches and configurable squash depth
module bgu_dual_issue_cond #(
  parameter int              PC_W         = 9,
  parameter int              IMM_W        = 8,
  parameter int              SQUASH_DEPTH = 1,
  parameter logic [PC_W-1:0] RESET_PC     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_next_in,
  input  logic            N,
  input  logic            V,
  input  logic            Z,
  input  logic [15:0]     p0_IR_in,
  input  logic [15:0]     p1_IR_in,
  output logic [PC_W-1:0] fetch_addr_out,
  output logic [PC_W-1:0] pc_next_out,
  output logic            slot0_valid_out,
  output logic            slot1_valid_out,
  output logic            branch_taken_out,
  output logic            branch_slot_out,
  output logic            squash_out
);

  localparam int SQ_W = (SQUASH_DEPTH < 2) ? 1 : $clog2(SQUASH_DEPTH + 1);
  // Offset is sign-extended to whichever is wider, then reduced modulo 2^PC_W.
  localparam int SX_W = (IMM_W > PC_W) ? IMM_W : PC_W;
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_DEPTH);

  // Architectural state
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_bundle_pc;
  logic            r_bundle_vld;
  logic            r_odd;
  logic            r_odd_d1;
  logic [SQ_W-1:0] r_squash_cnt;

  // Decode / resolve signals
  logic            w_live;
  logic            w_elig0;
  logic            w_hit0;
  logic            w_hit1;
  logic            w_take0;
  logic            w_take1;
  logic            w_taken;
  logic [PC_W-1:0] w_base0;
  logic [PC_W-1:0] w_base1;
  logic [SX_W-1:0] w_off0_x;
  logic [SX_W-1:0] w_off1_x;
  logic [PC_W-1:0] w_tgt0;
  logic [PC_W-1:0] w_tgt1;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_seq_pc;
  logic [PC_W-1:0] w_pc_next;
  logic            w_unused;

  // Branch condition evaluation: opcode 001, condition field in IR[12:10].
  function automatic logic br_hit(input logic [15:0] ir, input logic n, input logic v,
                                  input logic z);
    logic t;
    t = 1'b0;
    if (ir[15:13] == 3'b001) begin
      case (ir[12:10])
        3'b000:  t = 1'b1;
        3'b001:  t = z;
        3'b010:  t = ~z;
        3'b011:  t = n ^ v;
        3'b100:  t = (n ^ v) | z;
        default: t = 1'b0;
      endcase
    end
    return t;
  endfunction

  // A bundle is decoded only once it has been fetched and is not on the wrong path.
  assign w_live  = r_bundle_vld & (r_squash_cnt == '0);
  // Slot 0 is skipped when the bundle was entered through an odd jump target.
  assign w_elig0 = w_live & ~r_odd_d1;

  assign w_base0 = r_bundle_pc + PC_W'(1);
  assign w_base1 = r_bundle_pc + PC_W'(2);

  assign w_off0_x = SX_W'($signed(p0_IR_in[IMM_W-1:0]));
  assign w_off1_x = SX_W'($signed(p1_IR_in[IMM_W-1:0]));

  assign w_tgt0 = w_base0 + w_off0_x[PC_W-1:0];
  assign w_tgt1 = w_base1 + w_off1_x[PC_W-1:0];

  // Slot-0 and slot-1 branch resolution; a taken slot 0 shadows slot 1.
  always_comb begin
    w_hit0  = br_hit(p0_IR_in, N, V, Z);
    w_hit1  = br_hit(p1_IR_in, N, V, Z);
    w_take0 = w_elig0 & w_hit0;
    w_take1 = w_live & ~w_take0 & w_hit1;
    w_taken = w_take0 | w_take1;
  end

  // Next-PC selection: redirect on a taken branch, otherwise step one bundle.
  always_comb begin
    w_seq_pc  = {r_pc[PC_W-1:1] + (PC_W-1)'(1), r_pc[0]};
    w_target  = w_take0 ? w_tgt0 : w_tgt1;
    w_pc_next = w_taken ? w_target : w_seq_pc;
  end

  // State update, frozen while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_bundle_pc  <= RESET_PC;
      r_bundle_vld <= 1'b0;
      r_odd        <= 1'b0;
      r_odd_d1     <= 1'b0;
      r_squash_cnt <= '0;
    end else if (fetch_next_in) begin
      r_pc         <= w_pc_next;
      r_bundle_pc  <= {r_pc[PC_W-1:1], 1'b0};
      r_bundle_vld <= 1'b1;
      // Only a redirect marks the fetched bundle; the mask is applied once, in decode.
      r_odd        <= w_taken & w_target[0];
      r_odd_d1     <= r_odd;
      if (w_taken) begin
        r_squash_cnt <= SQ_LOAD;
      end else if (r_squash_cnt != '0) begin
        r_squash_cnt <= r_squash_cnt - SQ_W'(1);
      end
    end
  end

  assign fetch_addr_out   = {r_pc[PC_W-1:1], 1'b0};
  assign pc_next_out      = w_pc_next;
  assign slot0_valid_out  = w_elig0;
  assign slot1_valid_out  = w_live & ~w_take0;
  assign branch_taken_out = w_taken;
  assign branch_slot_out  = w_take1;
  assign squash_out       = (r_squash_cnt != '0);

  // IR bits above the offset field and the widened offset MSBs are not consumed.
  assign w_unused = ^{p0_IR_in, p1_IR_in, w_off0_x, w_off1_x};

endmodule
